// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: FSM state encoding and frame line levels.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: down-counter that strobes tick in the last cycle of each bit time,
// and pre_tick one cycle earlier so callers can register signals aligned to that last cycle.
module bit_timer #(
  parameter int CLK_PER_BIT = 217
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(CLK_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - CNT_W'(1);
    if (restart || (cnt_q == '0)) begin
      cnt_d = LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick     = (cnt_q == '0);
  assign pre_tick = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts bytes over valid/ready and serialises them as start, 8 data
// bits LSB first and STOP_BITS stop bits, chaining frames with no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 217,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]           idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 restart, tick, pre_tick;
  logic                 hs, last_stop;

  bit_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  assign hs        = tx_valid && ready_q;
  assign last_stop = (stop_q == 1'(STOP_BITS - 1));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      IDLE: begin
        txd_d   = STOP_LVL;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (hs) begin
          state_d = START;
          shreg_d = tx_data;
          txd_d   = START_LVL;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          restart = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = 3'd0;
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
            stop_d  = 1'b0;
            txd_d   = STOP_LVL;
          end else begin
            idx_d   = idx_q + 3'd1;
            txd_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      STOP: begin
        // Ready is registered, so raise it one cycle ahead of the final stop-bit tick.
        if (last_stop && pre_tick) begin
          ready_d = 1'b1;
        end
        if (tick) begin
          if (!last_stop) begin
            stop_d = 1'b1;
          end else if (hs) begin
            state_d = START;
            shreg_d = tx_data;
            txd_d   = START_LVL;
            restart = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      txd_q   <= STOP_LVL;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    idx_q   <= idx_d;
    stop_q  <= stop_d;
  end

  assign tx_ready = ready_q;
  assign txd      = txd_q;
  assign busy     = busy_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drains a valid/ready byte stream and emits asynchronous 8N1 (or 8N2) frames on a single output pin. It sits directly downstream of a `sync_fifo` read port (`rd_data`/`rd_valid`/`rd_ready`), turning buffered bytes into a UART line at a fixed divided bit rate. It sustains back-to-back frames with no idle gap whenever the source keeps `tx_valid` high.

## Interface
- `CLK_PER_BIT`, default 217: clock cycles per serial bit. Legal range is 2 or more; 217 gives 115200 baud at 25 MHz.
- `STOP_BITS`, default 1: stop bits per frame. Legal values are 1 or 2.
- `clk` input, 1 bit: the single clock. All logic is on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `tx_data` input, 8 bits: byte to send. Sampled only on a handshake.
- `tx_valid` input, 1 bit: source has a byte on `tx_data`.
- `tx_ready` output, 1 bit, registered: transmitter will accept a byte this cycle.
- `txd` output, 1 bit, registered: serial line. Idle level is 1.
- `busy` output, 1 bit, registered: a frame is in progress on `txd`.

## Operation
- A handshake occurs when `tx_valid` and `tx_ready` are both high at a rising edge. On that edge the byte is captured into a shift register.
- The frame is sent in this order:
  - start bit: 0;
  - data bits d0..d7, LSB first;
  - `STOP_BITS` stop bits: 1.
- Each bit is held for exactly `CLK_PER_BIT` cycles.
- State machine states and transitions:
  - IDLE: `txd`=1, `busy`=0, `tx_ready`=1. A handshake moves to START.
  - START: one bit time, then DATA.
  - DATA: eight bit times, counted by a 3-bit index. After d7 completes, move to STOP.
  - STOP: `STOP_BITS` bit times.
    - In the final cycle of the final stop bit, `tx_ready`=1.
    - If a handshake occurs in that cycle, move to START and emit no idle cycle.
    - Otherwise move to IDLE.
- `tx_ready` is 0 in every other cycle of a frame.
- While `tx_ready`=0, changes on `tx_data` and `tx_valid` are ignored. A source holding `tx_valid` high while busy loses nothing.
- Arithmetic and width rules:
  - The bit-time counter is `$clog2(CLK_PER_BIT)` bits wide. It counts down from `CLK_PER_BIT`-1 to 0.
  - The stop-bit counter is 1 bit.
  - There is no arithmetic on `tx_data`.
- Reset values: state=IDLE, `txd`=1, `busy`=0, `tx_ready`=0.
  - `tx_ready` rises in the first cycle after `reset` deasserts.
  - This matches the `sync_fifo` convention where `wr_ready` comes up one cycle after start-up.
- Reset mid-frame:
  - The frame is abandoned. `txd`=1 and `busy`=0 from the next cycle.
  - The captured byte is discarded and no handshake is owed.
  - A truncated frame on the line is acceptable.
- Reset has priority over a simultaneous handshake. The byte is not accepted.

## Timing
- Let a handshake happen at edge E.
  - `txd` goes to 0 and `busy` to 1 in the cycle after E.
  - The start bit occupies cycles E+1 .. E+`CLK_PER_BIT`.
  - Data bit i occupies cycles E+1+(i+1)·`CLK_PER_BIT` .. E+(i+2)·`CLK_PER_BIT`.
- Frame length is exactly (9+`STOP_BITS`)·`CLK_PER_BIT` cycles. This gives 10·CPB for 1 stop bit and 11·CPB for 2.
- With `tx_valid` held high, consecutive start bits are exactly one frame length apart.
- `busy` falls in the cycle after the last stop-bit cycle, and only when no chained handshake occurred.
- `txd` is glitch-free because it is driven straight from a flop.

## Structure
- `uart_pkg` package holds:
  - the state enum (IDLE, START, DATA, STOP), 2 bits;
  - the frame constants: start level 0, stop/idle level 1, 8 data bits.
- A sub-module is natural: `bit_timer`, parameterized by `CLK_PER_BIT`.
  - Inputs: `clk`, `reset`, `restart`.
  - Output: `tick`, a one-cycle strobe in the last cycle of each bit time.
  - The future `uart_rx` reuses it.
- The top level holds the FSM, the shift register, the bit index and the stop counter.

## Test plan
All scenarios use `CLK_PER_BIT`=4 unless noted.

- **Reset bring-up:** hold `reset` 3 cycles, then release. `txd`=1, `busy`=0 and `tx_ready`=0 during reset; `tx_ready`=1 on the first cycle after release.
- **Single byte:** send 0x55 with a one-cycle `tx_valid` pulse. `txd` sequence per 4-cycle bit is 0,1,0,1,0,1,0,1,0,1. `tx_ready`=0 for cycles E+1..E+39, then 1. `busy` falls at E+41.
- **Back-to-back via sync_fifo:** preload 0xA5 and 0x3C, with `tx_valid` continuously high.
  - Start bits are 40 cycles apart with no idle cycle.
  - Bits decode LSB first as 1,0,1,0,0,1,0,1 and then 0,0,1,1,1,1,0,0.
- **Source stall:** drive `tx_valid`=1 with `tx_data` changing every cycle while busy. Only the value present at the handshake edge is transmitted.
- **Two stop bits:** `STOP_BITS`=2, send 0xFF. `txd` is low only for the start bit, and the frame is 44 cycles.
- **Reset mid-frame:** assert `reset` during data bit 3 of 0x00.
  - `txd`=1 and `busy`=0 the next cycle.
  - After release, sending 0x81 yields a correct full frame.
